// File: rtl/sync_ram_be.sv
// sync_ram_be: single-port synchronous RAM with byte-enable writes, a
// registered read port with a valid strobe, and a post-reset clear sweep
// that zeroes every word before requests are served.
// Optional feature macro: RAM_OUT_REG_EN adds a second output register
// stage (read latency 2 instead of 1).
module sync_ram_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     Data_in,
    output logic [DATA_W-1:0]     Data_out,
    output logic                  valid,
    output logic                  busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;

    // Control FSM: clear sweep after reset, then serve reads with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            clr_ptr  <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                INIT: begin
                    rd_valid <= 1'b0;
                    clr_ptr  <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    rd_valid <= enable && !we;
                    if (enable && !we) begin
                        rd_data <= mem[addr];
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage: sweep zeroes one word per cycle during INIT, byte-lane writes in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[clr_ptr] <= '0;
            end else if (enable && we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= Data_in[i*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    // Extra output stage; reset flushes any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= rd_valid;
            if (rd_valid) begin
                Data_out <= rd_data;
            end
        end
    end
`else
    // Single output stage: the read register drives the port directly.
    always_comb begin
        Data_out = rd_data;
        valid    = rd_valid;
    end
`endif

endmodule

// File: doc/sync_ram_be.md
# sync_ram_be

Parametrised single-port synchronous RAM with byte-enable writes, registered read data with a valid strobe, and a hardware clear sequence that zeroes every word after reset. It is the clocked, generalised successor to the team's 16 x 32 enable/addr scratch memory. It serves as the local data store behind the lab datapath blocks.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- enable  input  1  access request, sampled each rising edge
- we  input  1  1 = write, 0 = read; qualified by enable
- addr  input  ADDR_W  word address
- be  input  BE_W  byte lanes written when we=1; ignored on reads
- Data_in  input  DATA_W  write data
- Data_out  output  DATA_W  read data, holds last read value
- valid  output  1  one-cycle pulse: Data_out updated by a read
- busy  output  1  clear sequence running; requests ignored

## Operation
- States: INIT (clear sweep) and IDLE (serving requests).
- rst sampled high: state=INIT, clear pointer=0, busy=1, valid=0, Data_out=0. Memory contents are not reset directly; the sweep clears them.
- INIT: each edge with rst low writes 0 to mem[ptr] and increments ptr. The edge that clears word DEPTH-1 moves the block to IDLE, and busy=0 from that edge.
- INIT ignores enable entirely. Requests are not queued, valid stays 0, and memory is not written.
- IDLE write (enable=1, we=1): for each i with be[i]=1, mem[addr] byte i <= Data_in byte i. Other bytes are unchanged. be=0 is a legal no-op. A write does not change Data_out and produces no valid pulse.
- IDLE read (enable=1, we=0): Data_out <= mem[addr], and valid pulses for exactly one cycle.
- IDLE with enable=0: memory unchanged, Data_out held, valid=0.
- Back-to-back operations are allowed every cycle. A write to A followed by a read of A on the next edge returns the new data.
- rst asserted during INIT restarts the sweep from word 0. rst asserted during IDLE re-enters INIT. A read accepted on the same edge as rst is dropped.
- addr always indexes a valid word (DEPTH = 2**ADDR_W), so there is no out-of-range case.

## Timing
- Reset values: Data_out=0, valid=0, busy=1.
- Clear time: busy stays high for DEPTH edges after the first edge at which rst is low. For DEPTH=16, the first request is accepted on edge 17.
- Read latency is 1 cycle: address is sampled at edge N, and Data_out and valid are valid after edge N. Under RAM_OUT_REG_EN the latency is 2 cycles.
- Write latency: data is committed at the sampling edge and is visible to a read sampled at edge N+1.
- Throughput: one access per cycle.

## Configuration
- RAM_OUT_REG_EN defined:
  - adds a second output register stage; Data_out and valid are delayed one further cycle (read latency 2);
  - the pipeline stage resets to 0/0, and a reset flushes any in-flight read.
- RAM_OUT_REG_EN undefined: single output register, read latency 1.

## Test plan
- After reset, wait for busy=0, then read addr 5 -> Data_out=0x00000000 with a one-cycle valid pulse.
- Write 0x12345678 to addr 3 with be=4'hF, then read addr 3 on the next cycle -> Data_out=0x12345678, valid=1 for one cycle.
- Write 0xAABBCCDD to addr 7 with be=4'hF, then write 0x11223344 with be=4'b0101, then read -> 0xAA22CC44.
- While busy=1, issue a write of 0xDEADBEEF to addr 0; after busy falls, read addr 0 -> 0x00000000, and valid never pulses during INIT.
- Fill all 16 words, pulse rst for 1 cycle at sweep pointer 8, re-pulse it mid-sweep, then read every word -> all 0; busy duration equals exactly 16 cycles after the final rst deassertion.
- Regress twice, with and without RAM_OUT_REG_EN -> read data and valid appear 1 and 2 cycles after the read edge respectively.
